// File: rtl/dag_sched_pkg.sv
// Shared definitions for the DAG scheduler: default operand width, id-width
// helper and the result payload carried from the pipe into the response FIFO.
package dag_sched_pkg;

    localparam int BITS_DEF = 2;
    // Payload fields are sized for the largest supported configuration;
    // narrower builds zero-extend into them and truncate on the way out.
    localparam int BITS_MAX = 16;
    localparam int ID_W_MAX = 3;

    function automatic int id_w(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    typedef struct packed {
        logic [ID_W_MAX-1:0] id;
        logic [BITS_MAX-1:0] out0;
        logic                out1;
    } pipe_payload_t;

endpackage

// File: rtl/bm_dag_sched_if.sv
// Requester and response handshake bundle for bm_dag_sched.
// master: stimulus/consumer side, slave: the scheduler.
interface bm_dag_sched_if
    import dag_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int BITS = BITS_DEF
);
    localparam int IDW = id_w(NREQ);

    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*BITS-1:0] req_a;
    logic [NREQ*BITS-1:0] req_b;
    logic [NREQ-1:0]      req_c;
    logic [NREQ-1:0]      req_d;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [BITS-1:0]      rsp_out0;
    logic                 rsp_out1;

    modport master (
        output req_valid, req_a, req_b, req_c, req_d, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_out0, rsp_out1
    );

    modport slave (
        input  req_valid, req_a, req_b, req_c, req_d, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_out0, rsp_out1
    );

endinterface

// File: rtl/dag_eval_pipe.sv
// Bitwise DAG evaluation pipe. S1 and S2 are registered; S3 is the
// combinational tail that feeds the response FIFO write port.
module dag_eval_pipe
    import dag_sched_pkg::*;
#(
    parameter int BITS = BITS_DEF,
    parameter int IDW  = 2
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            in_valid,
    input  logic [BITS-1:0] in_a,
    input  logic [BITS-1:0] in_b,
    input  logic            in_c,
    input  logic            in_d,
    input  logic [IDW-1:0]  in_id,
    output logic            out_valid,
    output pipe_payload_t   out_data,
    output logic [1:0]      inflight
);
    localparam int STAGES = 2;

    logic [STAGES:1] vld_pipe;

    logic [BITS-1:0] s1_ta, s1_tb1, s1_a;
    logic            s1_tc1, s1_td1, s1_d;
    logic [IDW-1:0]  s1_id;

    logic [BITS-1:0] s2_ta, s2_tb;
    logic            s2_tc, s2_td;
    logic [IDW-1:0]  s2_id;

    // valid shift register; reset discards everything in flight
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) vld_pipe <= '0;
        else          vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
    end

    // S1 and S2 datapath registers with a, d and id travelling as sidecars
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_ta <= '0; s1_tb1 <= '0; s1_a <= '0;
            s1_tc1 <= 1'b0; s1_td1 <= 1'b0; s1_d <= 1'b0; s1_id <= '0;
            s2_ta <= '0; s2_tb <= '0; s2_tc <= 1'b0; s2_td <= 1'b0; s2_id <= '0;
        end else begin
            s1_ta  <= in_a & in_b;
            s1_tb1 <= in_a | in_b;
            s1_tc1 <= in_c & in_d;
            s1_td1 <= in_c ^ in_d;
            s1_a   <= in_a;
            s1_d   <= in_d;
            s1_id  <= in_id;
            s2_ta  <= s1_ta;
            s2_tb  <= s1_a ^ s1_tb1;
            s2_tc  <= s1_tc1 ^ s1_d;
            s2_td  <= s1_td1 | s1_d;
            s2_id  <= s1_id;
        end
    end

    // S3: final AND terms packed into the FIFO payload
    always_comb begin
        out_data      = '0;
        out_data.id   = ID_W_MAX'(s2_id);
        out_data.out0 = BITS_MAX'(s2_ta & s2_tb);
        out_data.out1 = s2_tc & s2_td;
    end

    assign out_valid = vld_pipe[STAGES];
    assign inflight  = 2'(vld_pipe[1]) + 2'(vld_pipe[2]);

endmodule

// File: rtl/bm_dag_sched.sv
// Round-robin scheduler sharing one dag_eval_pipe among NREQ requesters,
// with a credit-protected response FIFO.
// Optional: DAG_SCHED_STATS_EN builds saturating issue/stall counters.
module bm_dag_sched
    import dag_sched_pkg::*;
#(
    parameter int BITS      = BITS_DEF,
    parameter int NREQ      = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic          clock,
    input  logic          reset_n,
    bm_dag_sched_if.slave bus,
    output logic [15:0]   stat_issued,
    output logic [15:0]   stat_stalled
);
    localparam int IDW = id_w(NREQ);
    localparam int PW  = $clog2(RSP_DEPTH);
    localparam int CW  = PW + 1;

    logic [IDW-1:0]  rr_ptr, winner;
    logic            found, credit_ok, xfer;
    logic [NREQ-1:0] grant;
    logic [1:0]      inflight;

    logic            push, pop;
    pipe_payload_t   pipe_out, head;
    pipe_payload_t   fifo_mem [RSP_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   fifo_count;

    // Registered counts only, so rsp_ready never reaches req_ready.
    assign credit_ok = (int'(inflight) + int'(fifo_count)) < RSP_DEPTH;

    // first asserted requester at or after rr_ptr, wrapping modulo NREQ
    always_comb begin
        int j;
        j      = 0;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && bus.req_valid[j]) begin
                found  = 1'b1;
                winner = IDW'(j);
            end
        end
    end

    assign xfer          = found & credit_ok & reset_n;
    assign grant         = xfer ? (NREQ'(1) << winner) : '0;
    assign bus.req_ready = grant;

    // pointer advances past the winner only on a transfer
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)  rr_ptr <= '0;
        else if (xfer) rr_ptr <= (int'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
    end

    dag_eval_pipe #(.BITS(BITS), .IDW(IDW)) u_pipe (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (xfer),
        .in_a      (bus.req_a[int'(winner)*BITS +: BITS]),
        .in_b      (bus.req_b[int'(winner)*BITS +: BITS]),
        .in_c      (bus.req_c[winner]),
        .in_d      (bus.req_d[winner]),
        .in_id     (winner),
        .out_valid (push),
        .out_data  (pipe_out),
        .inflight  (inflight)
    );

    assign bus.rsp_valid = (fifo_count != '0);
    assign pop           = bus.rsp_valid & bus.rsp_ready;

    // FIFO storage; contents are don't-care until counted valid
    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= pipe_out;
    end

    // FIFO pointers and occupancy; credit guarantees push never overflows
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: ;
            endcase
        end
    end

    // Head fields are forced to zero while empty so reset shows clean outputs.
    assign head         = fifo_mem[rd_ptr];
    assign bus.rsp_id   = bus.rsp_valid ? IDW'(head.id)    : '0;
    assign bus.rsp_out0 = bus.rsp_valid ? BITS'(head.out0) : '0;
    assign bus.rsp_out1 = bus.rsp_valid & head.out1;

`ifdef DAG_SCHED_STATS_EN
    logic stall;
    assign stall = (|bus.req_valid) & ~xfer;

    // saturating transfer and blocked-cycle counters
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_issued  <= '0;
            stat_stalled <= '0;
        end else begin
            if (xfer  && stat_issued  != 16'hFFFF) stat_issued  <= stat_issued  + 16'd1;
            if (stall && stat_stalled != 16'hFFFF) stat_stalled <= stat_stalled + 16'd1;
        end
    end
`else
    assign stat_issued  = '0;
    assign stat_stalled = '0;
`endif

endmodule

// File: tb/tb_bm_dag_sched.sv
// Directed bench for bm_dag_sched: reset values, latency, round-robin order,
// back-pressure credit, function table, mid-stream reset and statistics.
module tb_bm_dag_sched;
    import dag_sched_pkg::*;

    localparam int NREQ = 4, BITS = 2, RSP_DEPTH = 4;
`ifdef DAG_SCHED_STATS_EN
    localparam int EXP_ISS = 10, EXP_STL = 6;
`else
    localparam int EXP_ISS = 0, EXP_STL = 0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] stat_issued, stat_stalled;
    int          checks = 0;
    int          errors = 0;

    bm_dag_sched_if #(.NREQ(NREQ), .BITS(BITS)) bus ();

    bm_dag_sched #(.BITS(BITS), .NREQ(NREQ), .RSP_DEPTH(RSP_DEPTH)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .bus          (bus),
        .stat_issued  (stat_issued),
        .stat_stalled (stat_stalled)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         id;
        logic [1:0] a, b;
        logic       c, d;
        logic [1:0] exp_out0;
        logic       exp_out1;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic [1:0] a, input logic [1:0] b,
                           input logic c, input logic d);
        bus.req_a[i*BITS +: BITS] = a;
        bus.req_b[i*BITS +: BITS] = b;
        bus.req_c[i] = c;
        bus.req_d[i] = d;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        step();
    endtask

    // waits (bounded) for a response; returns at a falling edge
    task automatic wait_rsp(input string name);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 8 && !ok; t++) begin
            @(negedge clock);
            if (bus.rsp_valid) ok = 1'b1;
        end
        chk({name, "_arrived"}, 32'(ok), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got [$];
        int nx, seen;

        vecs[0] = '{0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0};
        vecs[1] = '{1, 2'b11, 2'b11, 1'b0, 1'b1, 2'b00, 1'b1};
        vecs[2] = '{2, 2'b10, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0};
        vecs[3] = '{3, 2'b01, 2'b11, 1'b1, 1'b1, 2'b00, 1'b0};
        vecs[4] = '{3, 2'b11, 2'b10, 1'b0, 1'b1, 2'b00, 1'b1};
        vecs[5] = '{0, 2'b01, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0};
        vecs[6] = '{1, 2'b10, 2'b10, 1'b1, 1'b1, 2'b00, 1'b0};
        vecs[7] = '{2, 2'b11, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0};

        // reset state, with requests pending to show ready is held low
        bus.req_valid = '1;
        bus.req_a = '0; bus.req_b = '0; bus.req_c = '0; bus.req_d = '0;
        bus.rsp_ready = 1'b0;
        #3;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_id",    32'(bus.rsp_id),    32'd0);
        chk("rst_stat_iss",  32'(stat_issued),   32'd0);
        chk("rst_stat_stl",  32'(stat_stalled),  32'd0);
        bus.req_valid = '0;
        @(negedge clock);
        reset_n = 1'b1;
        step();

        // single request from requester 2, 3-cycle latency
        set_req(2, 2'b11, 2'b01, 1'b0, 1'b1);
        bus.req_valid = 4'b0100;
        @(negedge clock);
        chk("single_grant", 32'(bus.req_ready), 32'b0100);
        step();
        bus.req_valid = '0;
        @(negedge clock); chk("lat_cycle1", 32'(bus.rsp_valid), 32'd0);
        step();
        @(negedge clock); chk("lat_cycle2", 32'(bus.rsp_valid), 32'd0);
        step();
        @(negedge clock);
        chk("lat_cycle3", 32'(bus.rsp_valid), 32'd1);
        chk("single_id",   32'(bus.rsp_id),   32'd2);
        chk("single_out0", 32'(bus.rsp_out0), 32'd0);
        chk("single_out1", 32'(bus.rsp_out1), 32'd1);
        bus.rsp_ready = 1'b1;
        step();
        @(negedge clock); chk("single_popped", 32'(bus.rsp_valid), 32'd0);
        step();

        // fairness: all valid, one grant per cycle in index order
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 2'(i), 2'(3 - i), 1'(i & 1), 1'(i >> 1));
        bus.req_valid = '1;
        got.delete();
        for (int k = 0; k < 14; k++) begin
            @(negedge clock);
            if (k < 8) chk($sformatf("rr_grant%0d", k), 32'(bus.req_ready), 32'd1 << (k % 4));
            if (bus.rsp_valid) got.push_back(int'(bus.rsp_id));
            step();
            if (k == 7) bus.req_valid = '0;
        end
        chk("rr_rsp_count", 32'(got.size()), 32'd8);
        for (int k = 0; k < got.size() && k < 8; k++)
            chk($sformatf("rr_rsp_id%0d", k), 32'(got[k]), 32'(k % 4));

        // back-pressure: credit stops issue after RSP_DEPTH sets
        bus.rsp_ready = 1'b0;
        bus.req_valid = '1;
        nx = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (|bus.req_ready) nx++;
            step();
        end
        chk("bp_transfers", 32'(nx), 32'd4);
        @(negedge clock);
        chk("bp_ready_held", 32'(bus.req_ready), 32'd0);
        chk("bp_rsp_valid",  32'(bus.rsp_valid), 32'd1);
        step();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        got.delete();
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (bus.rsp_valid) got.push_back(int'(bus.rsp_id));
            step();
        end
        chk("bp_drain_count", 32'(got.size()), 32'd4);
        for (int k = 0; k < got.size() && k < 4; k++)
            chk($sformatf("bp_drain_id%0d", k), 32'(got[k]), 32'(k));
        bus.req_valid = '1;
        @(negedge clock);
        chk("bp_resume", 32'(bus.req_ready), 32'b0001);
        step();
        bus.req_valid = '0;
        wait_rsp("bp_resume_rsp");
        chk("bp_resume_id", 32'(bus.rsp_id), 32'd0);
        step();

        // function table: out0 always 0, out1 = ~c & d
        for (int v = 0; v < 8; v++) begin
            set_req(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].d);
            bus.req_valid = 4'd1 << vecs[v].id;
            @(negedge clock);
            chk($sformatf("vec%0d_grant", v), 32'(bus.req_ready), 32'd1 << vecs[v].id);
            step();
            bus.req_valid = '0;
            wait_rsp($sformatf("vec%0d", v));
            chk($sformatf("vec%0d_id", v),   32'(bus.rsp_id),   32'(vecs[v].id));
            chk($sformatf("vec%0d_out0", v), 32'(bus.rsp_out0), 32'(vecs[v].exp_out0));
            chk($sformatf("vec%0d_out1", v), 32'(bus.rsp_out1), 32'(vecs[v].exp_out1));
            step();
        end

        // reset with three sets in flight/queued
        bus.req_valid = '1;
        bus.rsp_ready = 1'b0;
        step(); step(); step();
        reset_n = 1'b0;
        #2;
        chk("mid_rst_ready", 32'(bus.req_ready), 32'd0);
        chk("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid_rst_id",    32'(bus.rsp_id),    32'd0);
        chk("mid_rst_out0",  32'(bus.rsp_out0),  32'd0);
        chk("mid_rst_out1",  32'(bus.rsp_out1),  32'd0);
        chk("mid_rst_stat",  32'(stat_issued),   32'd0);
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            @(negedge clock);
            if (bus.rsp_valid) seen++;
        end
        chk("mid_rst_no_rsp", 32'(seen), 32'd0);
        bus.req_valid = '1;
        #1;
        chk("mid_rst_rr_ptr", 32'(bus.req_ready), 32'b0001);
        step();
        bus.req_valid = '0;
        wait_rsp("mid_rst_rsp");
        chk("mid_rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        step();

        // statistics: 4 grants + 6 blocked cycles, then 6 unblocked grants
        do_reset();
        bus.rsp_ready = 1'b0;
        bus.req_valid = '1;
        repeat (10) step();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        repeat (6) step();
        bus.req_valid = 4'b0001;
        repeat (6) step();
        bus.req_valid = '0;
        repeat (4) step();
        @(negedge clock);
        chk("stat_issued",  32'(stat_issued),  32'(EXP_ISS));
        chk("stat_stalled", 32'(stat_stalled), 32'(EXP_STL));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
